// File: rtl/gcd_pkg.sv
// Shared types for the gcd client: FSM states and the default operand pair.
package gcd_pkg;
  localparam int GCD_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [GCD_W-1:0] a;
    logic [GCD_W-1:0] b;
  } pair_t;
endpackage

// File: rtl/gcd_client_fifo.sv
// Operand-pair FIFO: wrapping read/write pointers plus an occupancy count.
module gcd_client_fifo
  import gcd_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = pair_t
) (
  input  logic clk,
  input  logic nrst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/gcd_client.sv
// Initiator for the subtractive gcd core; zero operands are answered locally.
// Define GCD_CLIENT_CYCLES_EN to add the res_cycles core-latency output.
module gcd_client
  import gcd_pkg::*;
#(
  parameter int W     = GCD_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         core_start,
  output logic [W-1:0] core_ina,
  output logic [W-1:0] core_inb,
  input  logic         core_ready,
  input  logic [W-1:0] core_out
`ifdef GCD_CLIENT_CYCLES_EN
  ,
  output logic [15:0]  res_cycles
`endif
);
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_w_t;

  state_t  state;
  state_t  nxt;
  pair_w_t head;
  pair_w_t din;
  logic    full;
  logic    empty;
  logic    pop;
  logic    zero_op;

  assign din      = '{a: in_a, b: in_b};
  assign in_ready = !full;
  assign zero_op  = (head.a == '0) || (head.b == '0);
  assign core_ina = head.a;
  assign core_inb = head.b;
  assign res_valid = (state == S_RESP);

  gcd_client_fifo #(.DEPTH(DEPTH), .T(pair_w_t)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (in_valid),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt        = state;
    pop        = 1'b0;
    core_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          if (zero_op) begin
            pop = 1'b1;
            nxt = S_RESP;
          end else if (core_ready) begin
            core_start = 1'b1;
            pop        = 1'b1;
            nxt        = S_WAIT;
          end
        end
      end
      S_WAIT: if (core_ready) nxt = S_RESP;
      S_RESP: if (res_ready)  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Result register: loaded on entry to RESP, held until the handshake.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      res_data <= '0;
    end else if (state == S_IDLE && !empty && zero_op) begin
      res_data <= head.a | head.b;
    end else if (state == S_WAIT && core_ready) begin
      res_data <= core_out;
    end
  end

`ifdef GCD_CLIENT_CYCLES_EN
  logic [15:0] cyc_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // cyc_cnt counts WAIT cycles, including the one in which the core reports ready.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cyc_cnt    <= '0;
      res_cycles <= '0;
    end else begin
      if (core_start) cyc_cnt <= 16'd1;
      else if (state == S_WAIT && !core_ready) cyc_cnt <= sat_inc(cyc_cnt);
      if (state == S_IDLE && !empty && zero_op) res_cycles <= '0;
      else if (state == S_WAIT && core_ready) res_cycles <= cyc_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_gcd_client.sv
// Scoreboard bench for gcd_client driving a behavioural subtractive gcd core.
module tb_gcd_client;
  import gcd_pkg::*;

  logic       clk = 1'b0;
  logic       nrst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       core_start;
  logic [7:0] core_ina;
  logic [7:0] core_inb;
  logic       core_ready;
  logic [7:0] core_out;
`ifdef GCD_CLIENT_CYCLES_EN
  logic [15:0] res_cycles;
`endif

  gcd_client #(.W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .core_start (core_start),
    .core_ina   (core_ina),
    .core_inb   (core_inb),
    .core_ready (core_ready),
    .core_out   (core_out)
`ifdef GCD_CLIENT_CYCLES_EN
    ,
    .res_cycles (res_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Subtractive gcd core sharing nrst; loads operands on the start edge.
  logic [7:0] ca;
  logic [7:0] cb;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ca <= '0;
      cb <= '0;
    end else if (core_start) begin
      ca <= core_ina;
      cb <= core_inb;
    end else if (ca > cb) begin
      ca <= ca - cb;
    end else if (cb > ca) begin
      cb <= cb - ca;
    end
  end
  assign core_ready = (ca == cb);
  assign core_out   = ca;

  int   n_vec   = 0;
  int   n_err   = 0;
  int   n_got   = 0;
  int   n_start = 0;
  int   cyc     = 0;
  int   t_start = 0;
  int   t_valid = 0;
  int   t_push  = 0;
  logic rv_d    = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (core_start) begin
      n_start++;
      t_start = cyc;
    end
    if (res_valid && !rv_d) t_valid = cyc;
    rv_d = res_valid;
  end

  // Monitor: pops the scoreboard on every result handshake.
  always @(negedge clk) begin
    if (nrst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
      end else begin
        chk("result", 32'(res_data), 32'(exp_q.pop_front()));
        n_got++;
      end
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
    int t = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("push_timeout", 32'(in_ready), 32'd1);
    end else begin
      exp_q.push_back(exp);
      t_push = cyc;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || res_valid) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int s0;
  int g0;
  int t;

  initial begin
    nrst      = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    s0 = n_start;
    push(8'd12, 8'd18, 8'd6);
    wait_drain();
    chk("start_pulses_12_18", 32'(n_start - s0), 32'd1);

    push(8'd7, 8'd7, 8'd7);
    wait_drain();
    chk("latency_7_7", 32'(t_valid - t_start), 32'd2);

    s0 = n_start;
    push(8'd0, 8'd9, 8'd9);
    wait_drain();
    chk("latency_zero", 32'(t_valid - t_push), 32'd2);
    push(8'd5, 8'd0, 8'd5);
    push(8'd0, 8'd0, 8'd0);
    wait_drain();
    chk("start_pulses_zero", 32'(n_start - s0), 32'd0);

    // Back-to-back with the consumer stalled: one result held, four buffered.
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    g0 = n_got;
    fork
      begin
        push(8'd4,  8'd6,  8'd2);
        push(8'd9,  8'd3,  8'd3);
        push(8'd10, 8'd15, 8'd5);
        push(8'd21, 8'd14, 8'd7);
        push(8'd1,  8'd1,  8'd1);
        push(8'd16, 8'd24, 8'd8);
      end
      begin
        repeat (30) @(negedge clk);
        chk("in_ready_full", 32'(in_ready), 32'd0);
        chk("res_valid_stalled", 32'(res_valid), 32'd1);
        @(posedge clk);
        #1 res_ready = 1'b1;
      end
    join
    wait_drain();
    chk("b2b_results", 32'(n_got - g0), 32'd6);

    // Reset while the core is busy on (200,3).
    s0 = n_start;
    push(8'd200, 8'd3, 8'd1);
    t = 0;
    while (n_start == s0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    chk("in_wait_before_reset", 32'(dut.state), 32'(S_WAIT));
    nrst = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_res_data", 32'(res_data), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("midrst_state", 32'(dut.state), 32'(S_IDLE));
    chk("midrst_fifo_empty", 32'(dut.u_fifo.empty), 32'd1);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    push(8'd8, 8'd12, 8'd4);
    wait_drain();

`ifdef GCD_CLIENT_CYCLES_EN
    push(8'd1, 8'd255, 8'd1);
    wait_drain();
    chk("res_cycles_measured", 32'(res_cycles), 32'(t_valid - t_start - 1));
    chk("res_cycles_1_255", 32'(res_cycles), 32'd255);
    push(8'd0, 8'd4, 8'd4);
    wait_drain();
    chk("res_cycles_zero", 32'(res_cycles), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
